// File: rtl/rom_uploader.sv
// rom_uploader: answers ioctl upload (read-back) strobes by reading the ROM
// region map through RAM port B. ioctl_wait covers the RAM latency, and the
// block keeps a running checksum and byte count for the HPS side.
module rom_uploader #(
  parameter logic [24:0] BASE   = 25'h00000,
  parameter logic [24:0] SIZE   = 25'h58300,
  parameter int          RD_LAT = 1,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [24:0] RD_ADDR,
  output logic        RD_EN,
  input  logic [7:0]  RD_DATA,
  output logic [15:0] SUM,
  output logic [24:0] COUNT,
  output logic        OVERRUN
);

  typedef enum logic [1:0] {IDLE, ISSUE, LAT, DONE} state_t;

  // The latency counter counts RD_LAT-1 down to 0, so two bits cover 1..4.
  localparam logic [1:0]  LAT_LOAD  = 2'(RD_LAT - 1);
  localparam logic [24:0] COUNT_MAX = 25'h1FFFFFF;

  state_t      state_q, state_d;
  logic [24:0] offs_q, offs_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  din_q, din_d;
  logic [15:0] sum_q, sum_d;
  logic [24:0] count_q, count_d;
  logic        overrun_q, overrun_d;
  logic        upload_q;

  logic        strobe;
  logic        session_start;
  logic [25:0] diff;
  logic        in_range;

  assign strobe        = ioctl_rd & ioctl_upload;
  assign session_start = ioctl_upload & ~upload_q;

  // A borrow out of the 26-bit subtract means the address is below BASE;
  // the offset is only compared against SIZE when there is no borrow.
  assign diff     = {1'b0, ioctl_addr} - {1'b0, BASE};
  assign in_range = ~diff[25] && (diff[24:0] < SIZE);

  // Next-state and datapath: decide what every register holds after this edge.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    offs_d    = offs_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    din_d     = din_q;
    sum_d     = session_start ? 16'h0000 : sum_q;
    count_d   = session_start ? 25'h0 : count_q;
    overrun_d = session_start ? 1'b0 : overrun_q;

    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (in_range) begin
            offs_d  = diff[24:0];
            state_d = ISSUE;
          end else begin
            pend_d  = FILL;
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (!ioctl_upload) begin
          state_d = IDLE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = LAT;
        end
      end
      LAT: begin
        if (!ioctl_upload) begin
          state_d = IDLE;
        end else if (cnt_q == 2'd0) begin
          pend_d  = RD_DATA;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE: begin
        din_d   = pend_q;
        sum_d   = sum_d + {8'h00, pend_q};
        count_d = (count_d == COUNT_MAX) ? count_d : count_d + 25'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A strobe that arrives while a request is in flight is dropped.
    if (strobe && (state_q != IDLE)) overrun_d = 1'b1;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      state_q   <= IDLE;
      offs_q    <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      din_q     <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      upload_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      offs_q    <= offs_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      din_q     <= din_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      upload_q  <= ioctl_upload;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = (state_q != IDLE);
  assign RD_EN      = (state_q == ISSUE);
  assign RD_ADDR    = offs_q;
  assign SUM        = sum_q;
  assign COUNT      = count_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_rom_uploader.sv
// Directed bench for rom_uploader: one instance with RD_LAT=1 and one with
// RD_LAT=4, each fed by a small port-B RAM model with matching latency.
module tb_rom_uploader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // RAM contents: addr[7:0]^A0, or all 0xFF when ram_ff is set.
  logic ram_ff = 1'b0;
  function automatic logic [7:0] ram_byte(input logic [24:0] a);
    return ram_ff ? 8'hFF : (a[7:0] ^ 8'hA0);
  endfunction

  // ---------------- instance with RD_LAT = 1 ----------------
  logic        rst1 = 1'b1, up1 = 1'b0, rd1 = 1'b0;
  logic [24:0] addr1 = '0;
  logic [7:0]  din1, rdd1;
  logic        wait1, rden1, ovr1;
  logic [24:0] rda1, cnt1;
  logic [15:0] sum1;
  int          en_cnt1 = 0;

  rom_uploader #(.BASE(25'h0), .SIZE(25'h58300), .RD_LAT(1), .FILL(8'hFF)) u1 (
    .CLK(clk), .RESET(rst1), .ioctl_upload(up1), .ioctl_rd(rd1),
    .ioctl_addr(addr1), .ioctl_din(din1), .ioctl_wait(wait1),
    .RD_ADDR(rda1), .RD_EN(rden1), .RD_DATA(rdd1),
    .SUM(sum1), .COUNT(cnt1), .OVERRUN(ovr1)
  );

  // One-stage RAM model; data is only valid in the single cycle it is due.
  always @(posedge clk) begin
    rdd1 <= rden1 ? ram_byte(rda1) : 8'h00;
    if (rden1) en_cnt1 <= en_cnt1 + 1;
  end

  // ---------------- instance with RD_LAT = 4 ----------------
  logic        rst4 = 1'b1, up4 = 1'b0, rd4 = 1'b0;
  logic [24:0] addr4 = '0;
  logic [7:0]  din4;
  logic        wait4, rden4, ovr4;
  logic [24:0] rda4, cnt4;
  logic [15:0] sum4;
  logic [7:0]  pipe4 [4];
  int          en_cnt4 = 0;

  rom_uploader #(.BASE(25'h0), .SIZE(25'h58300), .RD_LAT(4), .FILL(8'hFF)) u4 (
    .CLK(clk), .RESET(rst4), .ioctl_upload(up4), .ioctl_rd(rd4),
    .ioctl_addr(addr4), .ioctl_din(din4), .ioctl_wait(wait4),
    .RD_ADDR(rda4), .RD_EN(rden4), .RD_DATA(pipe4[3]),
    .SUM(sum4), .COUNT(cnt4), .OVERRUN(ovr4)
  );

  // Four-stage RAM model.
  always @(posedge clk) begin
    pipe4[0] <= rden4 ? ram_byte(rda4) : 8'h00;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
    if (rden4) en_cnt4 <= en_cnt4 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge: outputs are checked and inputs driven there.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // ---- reset values ----
    cyc();
    check("rst din",   din1,  0);
    check("rst wait",  wait1, 0);
    check("rst rden",  rden1, 0);
    check("rst rdaddr", rda1, 0);
    check("rst sum",   sum1,  0);
    check("rst count", cnt1,  0);
    check("rst ovr",   ovr1,  0);
    cyc();
    rst1 = 1'b0;
    rst4 = 1'b0;
    up1  = 1'b1;
    up4  = 1'b1;
    cyc();

    // ---- single in-range read, RD_LAT=1: 0x12005 -> 0xA5 ----
    rd1 = 1'b1; addr1 = 25'h12005;
    cyc();
    rd1 = 1'b0;
    check("rd1 rden e0",  rden1, 1);
    check("rd1 rdaddr",   rda1,  25'h12005);
    check("rd1 wait c1",  wait1, 1);
    cyc();
    check("rd1 rden e1",  rden1, 0);
    check("rd1 wait c2",  wait1, 1);
    cyc();
    check("rd1 wait c3",  wait1, 1);
    check("rd1 din early", din1, 0);
    cyc();
    check("rd1 wait end", wait1, 0);
    check("rd1 din",      din1,  8'hA5);
    check("rd1 sum",      sum1,  16'h00A5);
    check("rd1 count",    cnt1,  1);

    // ---- out-of-range read, back-to-back: 0x58300 -> FILL ----
    rd1 = 1'b1; addr1 = 25'h58300;
    cyc();
    rd1 = 1'b0;
    check("oor wait c1", wait1, 1);
    check("oor rden",    rden1, 0);
    check("oor din hold", din1, 8'hA5);
    cyc();
    check("oor wait end", wait1, 0);
    check("oor din",     din1,  8'hFF);
    check("oor sum",     sum1,  16'h01A4);
    check("oor count",   cnt1,  2);

    // ---- last in-range address: 0x582FF -> 0x5F ----
    rd1 = 1'b1; addr1 = 25'h582FF;
    cyc();
    rd1 = 1'b0;
    check("last rden",   rden1, 1);
    check("last rdaddr", rda1,  25'h582FF);
    cyc(); cyc(); cyc();
    check("last din",    din1,  8'h5F);
    check("last sum",    sum1,  16'h0203);
    check("last count",  cnt1,  3);

    // ---- overrun: second strobe one cycle after the first ----
    rd1 = 1'b1; addr1 = 25'h00010;
    cyc();
    addr1 = 25'h00020;
    check("ovr rden e0",  rden1, 1);
    check("ovr rdaddr",   rda1,  25'h00010);
    check("ovr flag pre", ovr1,  0);
    cyc();
    rd1 = 1'b0;
    check("ovr flag",     ovr1,  1);
    check("ovr rden e1",  rden1, 0);
    cyc();
    check("ovr rden e2",  rden1, 0);
    cyc();
    check("ovr din",      din1,  8'hB0);
    check("ovr count",    cnt1,  4);
    check("ovr sum",      sum1,  16'h02B3);
    check("ovr sticky",   ovr1,  1);
    check("ovr wait end", wait1, 0);
    cyc();
    check("ovr rden total", en_cnt1, 3);

    // ---- new session clears SUM, COUNT, OVERRUN but not ioctl_din ----
    up1 = 1'b0;
    cyc();
    up1 = 1'b1;
    cyc();
    check("sess ovr",   ovr1, 0);
    check("sess sum",   sum1, 0);
    check("sess count", cnt1, 0);
    check("sess din",   din1, 8'hB0);

    // ---- checksum wrap: 0x101 back-to-back reads of 0xFF ----
    ram_ff = 1'b1;
    for (int i = 0; i < 257; i++) begin
      rd1 = 1'b1; addr1 = 25'(i);
      cyc();
      rd1 = 1'b0;
      cyc(); cyc(); cyc();
    end
    ram_ff = 1'b0;
    check("wrap sum",   sum1, 16'hFFFF);
    check("wrap count", cnt1, 25'h101);
    check("wrap ovr",   ovr1, 0);
    check("wrap din",   din1, 8'hFF);
    check("wrap rden total", en_cnt1, 260);

    // ---- strobe outside a session is ignored ----
    up1 = 1'b0;
    cyc();
    rd1 = 1'b1; addr1 = 25'h00005;
    cyc();
    rd1 = 1'b0;
    check("nosess wait", wait1, 0);
    check("nosess rden", rden1, 0);
    check("nosess ovr",  ovr1,  0);
    check("nosess sum",  sum1,  16'hFFFF);

    // ---- RD_LAT=4 normal read: 0x33 -> 0x93, wait high 6 cycles ----
    rd4 = 1'b1; addr4 = 25'h00033;
    cyc();
    rd4 = 1'b0;
    check("l4 rden e0",  rden4, 1);
    check("l4 rdaddr",   rda4,  25'h00033);
    check("l4 wait c1",  wait4, 1);
    for (int k = 2; k <= 6; k++) begin
      cyc();
      check($sformatf("l4 wait c%0d", k), wait4, 1);
      check($sformatf("l4 rden c%0d", k), rden4, 0);
    end
    check("l4 din early", din4, 0);
    cyc();
    check("l4 wait end", wait4, 0);
    check("l4 din",      din4,  8'h93);
    check("l4 sum",      sum4,  16'h0093);
    check("l4 count",    cnt4,  1);

    // ---- abort: upload drops two cycles after the strobe ----
    rd4 = 1'b1; addr4 = 25'h00044;
    cyc();
    rd4 = 1'b0;
    cyc();
    up4 = 1'b0;
    check("abort wait pre", wait4, 1);
    cyc();
    check("abort wait",  wait4, 0);
    check("abort din",   din4,  8'h93);
    check("abort sum",   sum4,  16'h0093);
    check("abort count", cnt4,  1);
    repeat (5) cyc();
    check("abort din later", din4, 8'h93);
    check("abort cnt later", cnt4, 1);

    // ---- next session read after abort: 0x55 -> 0xF5 ----
    up4 = 1'b1;
    cyc();
    check("l4 sess sum",   sum4, 0);
    check("l4 sess count", cnt4, 0);
    rd4 = 1'b1; addr4 = 25'h00055;
    cyc();
    rd4 = 1'b0;
    repeat (5) cyc();
    check("post din early", din4, 8'h93);
    cyc();
    check("post din",   din4, 8'hF5);
    check("post sum",   sum4, 16'h00F5);
    check("post count", cnt4, 1);

    // ---- reset mid-request (during LAT) ----
    rd4 = 1'b1; addr4 = 25'h00066;
    cyc();
    rd4 = 1'b0;
    cyc(); cyc();
    rst4 = 1'b1;
    cyc();
    rst4 = 1'b0;
    check("mrst wait",   wait4, 0);
    check("mrst rden",   rden4, 0);
    check("mrst rdaddr", rda4,  0);
    check("mrst din",    din4,  0);
    check("mrst sum",    sum4,  0);
    check("mrst count",  cnt4,  0);
    check("mrst ovr",    ovr4,  0);
    repeat (6) cyc();
    check("mrst rden total", en_cnt4, 4);
    check("mrst wait later", wait4, 0);
    check("mrst din later",  din4,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
